alu_seq: RTL and testbench



---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 153 +++++++++++++++
 tb/tb_alu_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake/operand bundle for alu_seq: producer/consumer side uses master,
// the ALU itself uses slave.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             negative;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, negative
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, negative
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and a WIDTH-cycle shift-add multiplier.
// Define ALU_SAT_EN to make ADD/SUB saturate on signed overflow instead of wrapping.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;
    localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH + 1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             r_state;
    logic               r_inReady;
    logic               r_outValid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_overflow;
    logic               r_negative;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_result;
    logic               w_carry;
    logic               w_overflow;
    logic [2*WIDTH-1:0] w_accNext;

    always_comb begin
        w_sum      = {1'b0, bus.a} + {1'b0, bus.b};
        w_diff     = {1'b0, bus.a} - {1'b0, bus.b};
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_result   = w_sum[WIDTH-1:0];
                w_carry    = w_sum[WIDTH];
                w_overflow = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                // The borrow out of the extended subtraction is exactly a < b unsigned.
                w_result   = w_diff[WIDTH-1:0];
                w_carry    = w_diff[WIDTH];
                w_overflow = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  w_result = bus.a & bus.b;
            OP_OR:   w_result = bus.a | bus.b;
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_XOR:  w_result = bus.a ^ bus.b;
            OP_SLL:  w_result = ({1'b0, bus.b} >= SHIFT_LIM) ? '0 : (bus.a << bus.b);
            default: w_result = '0;
        endcase
`ifdef ALU_SAT_EN
        // Overflow only happens when the true result's sign is a's sign, so a's MSB picks the rail.
        if (w_overflow) begin
            w_result = {bus.a[WIDTH-1], {(WIDTH-1){~bus.a[WIDTH-1]}}};
        end
`endif
    end

    assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_negative <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_inReady <= 1'b0;
                        if (bus.op == OP_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
                            r_mplier <= bus.b;
                            r_acc    <= '0;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_state  <= BUSY;
                        end else begin
                            r_result   <= w_result;
                            r_zero     <= (w_result == '0);
                            r_negative <= w_result[WIDTH-1];
                            r_carry    <= w_carry;
                            r_overflow <= w_overflow;
                            r_outValid <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                    // Final iteration: publish the product straight from the adder output.
                    if (r_cnt == CNT_W'(1)) begin
                        r_result   <= w_accNext[WIDTH-1:0];
                        r_zero     <= (w_accNext[WIDTH-1:0] == '0);
                        r_negative <= w_accNext[WIDTH-1];
                        r_carry    <= |w_accNext[2*WIDTH-1:WIDTH];
                        r_overflow <= 1'b0;
                        r_outValid <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_overflow;
    assign bus.negative  = r_negative;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4: every op, flags, MUL latency,
// backpressure and asynchronous reset abort; expectations follow ALU_SAT_EN.
module tb_alu_seq;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nPass;

    alu_seq_if #(.WIDTH(W)) busIf ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Presents one operation and returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        busIf.op       = op;
        busIf.a        = a;
        busIf.b        = b;
        busIf.in_valid = 1'b1;
        @(posedge clk);
        #1;
        busIf.in_valid = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic z, input logic c, input logic o, input logic n,
                         input int expLat);
        int lat;
        int busy;
        applyStimulus(op, a, b);
        lat  = 1;
        busy = 0;
        while (!busIf.out_valid && lat < 50) begin
            if (!busIf.in_ready) busy++;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, lat, expLat);
        checkOutput({tag, ".busyCycles"}, busy, expLat - 1);
        checkOutput({tag, ".result"}, busIf.result, res);
        checkOutput({tag, ".zero"}, busIf.zero, z);
        checkOutput({tag, ".carry"}, busIf.carry, c);
        checkOutput({tag, ".overflow"}, busIf.overflow, o);
        checkOutput({tag, ".negative"}, busIf.negative, n);
        checkOutput({tag, ".inReadyDone"}, busIf.in_ready, 1'b0);
        busIf.out_ready = 1'b1;
        @(posedge clk);
        #1;
        busIf.out_ready = 1'b0;
        checkOutput({tag, ".inReadyAfter"}, busIf.in_ready, 1'b1);
        checkOutput({tag, ".outValidAfter"}, busIf.out_valid, 1'b0);
    endtask

    initial begin
        nChecks         = 0;
        nPass           = 0;
        rst_n           = 1'b1;
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b0;
        busIf.a         = '0;
        busIf.b         = '0;
        busIf.op        = 3'b000;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset.inReady", busIf.in_ready, 1'b1);
        checkOutput("reset.outValid", busIf.out_valid, 1'b0);
        checkOutput("reset.result", busIf.result, 4'h0);
        checkOutput("reset.zero", busIf.zero, 1'b0);
        checkOutput("reset.carry", busIf.carry, 1'b0);
        checkOutput("reset.overflow", busIf.overflow, 1'b0);
        checkOutput("reset.negative", busIf.negative, 1'b0);

        busIf.out_ready = 1'b1;
        @(posedge clk);
        #1;
        busIf.out_ready = 1'b0;
        checkOutput("idleOutReady.outValid", busIf.out_valid, 1'b0);
        checkOutput("idleOutReady.inReady", busIf.in_ready, 1'b1);

        runOp("add4p3", 3'b000, 4'h4, 4'h3, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        runOp("sub4m3", 3'b001, 4'h4, 4'h3, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        runOp("sub3m4", 3'b001, 4'h3, 4'h4, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        runOp("add0p0", 3'b000, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        runOp("addFp1", 3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        runOp("slt2_3", 3'b100, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        runOp("slt3_2", 3'b100, 4'h3, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        runOp("sltE_1", 3'b100, 4'hE, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        runOp("xorA6", 3'b101, 4'hA, 4'h6, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        runOp("sll3by2", 3'b110, 4'h3, 4'h2, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        runOp("sll3by5", 3'b110, 4'h3, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        runOp("mul3x5", 3'b111, 4'h3, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        runOp("mul7x7", 3'b111, 4'h7, 4'h7, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 5);
        runOp("mul0x9", 3'b111, 4'h0, 4'h9, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
`ifdef ALU_SAT_EN
        runOp("add7p1", 3'b000, 4'h7, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        runOp("sub8m1", 3'b001, 4'h8, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
`else
        runOp("add7p1", 3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        runOp("sub8m1", 3'b001, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1);
`endif

        // Backpressure: result held for three cycles while a stray request is ignored.
        applyStimulus(3'b010, 4'hC, 4'hA);
        checkOutput("bp.firstValid", busIf.out_valid, 1'b1);
        busIf.op       = 3'b000;
        busIf.a        = 4'h1;
        busIf.b        = 4'h1;
        busIf.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp.result", busIf.result, 4'h8);
            checkOutput("bp.outValid", busIf.out_valid, 1'b1);
            checkOutput("bp.inReady", busIf.in_ready, 1'b0);
        end
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b1;
        @(posedge clk);
        #1;
        busIf.out_ready = 1'b0;
        checkOutput("bp.release.inReady", busIf.in_ready, 1'b1);
        checkOutput("bp.release.outValid", busIf.out_valid, 1'b0);
        checkOutput("bp.release.result", busIf.result, 4'h8);
        checkOutput("bp.release.negative", busIf.negative, 1'b1);

        runOp("or5_2", 3'b011, 4'h5, 4'h2, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        // Reset in the second BUSY cycle of a multiply must clear outputs without a clock edge.
        applyStimulus(3'b111, 4'h7, 4'h3);
        @(posedge clk);
        #1;
        checkOutput("rstBusy.preInReady", busIf.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rstBusy.outValid", busIf.out_valid, 1'b0);
        checkOutput("rstBusy.result", busIf.result, 4'h0);
        checkOutput("rstBusy.inReady", busIf.in_ready, 1'b1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        runOp("postRstAdd", 3'b000, 4'h2, 4'h3, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        runOp("postRstMul", 3'b111, 4'h2, 4'h3, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 5);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
